// File: rtl/la_prbs_checker.sv
`default_nettype none
// la_prbs_checker -- self-seeding receive-side PRBS checker with lock tracking
// and a saturating mismatch counter.  Rev 1.0
module la_prbs_checker #(
   parameter int    N            = 8,
   parameter string TYPE         = "PRBS7",
   parameter int    LOCK_WORDS   = 4,
   parameter int    UNLOCK_WORDS = 4,
   parameter int    ERRW         = 16
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            en,
   input  logic            clear,
   input  logic            valid_in,
   input  logic [N-1:0]    din,
   output logic            locked,
   output logic            err,
   output logic [ERRW-1:0] errcnt,
   output logic            errsat
);

   localparam int K  = (TYPE == "PRBS15") ? 15 :
                       (TYPE == "PRBS23") ? 23 :
                       (TYPE == "PRBS31") ? 31 : 7;
   localparam int TB = (TYPE == "PRBS15") ? 14 :
                       (TYPE == "PRBS23") ? 18 :
                       (TYPE == "PRBS31") ? 28 : 6;
   localparam int PW = $clog2(N + 1);
   localparam int CW = $clog2(LOCK_WORDS + 1);
   localparam int BW = $clog2(UNLOCK_WORDS + 1);
   localparam logic [ERRW-1:0] CNT_MAX = {ERRW{1'b1}};

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state;
   logic [K-1:0]    hist;
   logic [CW-1:0]   clean_cnt;
   logic [BW-1:0]   bad_cnt;

   logic [K+N-1:0]  seq;
   logic [N-1:0]    pred;
   logic [N-1:0]    mis;
   logic [PW-1:0]   popcnt;
   logic [ERRW:0]   sum;
   logic            any_mis;

   // seq[j] is bit j of {history oldest-first, word}; once locked the word
   // slots carry the predicted bits so the reference free-runs.
   always_comb begin
      seq  = {{N{1'b0}}, hist};
      pred = '0;
      for (int i = 0; i < N; i++) begin
         pred[i]  = seq[i] ^ seq[i + K - TB];
         seq[K+i] = (state == LOCKED) ? pred[i] : din[i];
      end
      mis     = din ^ pred;
      any_mis = |mis;
      popcnt  = '0;
      for (int i = 0; i < N; i++) begin
         popcnt = popcnt + PW'(mis[i]);
      end
      sum = {1'b0, errcnt} + (ERRW + 1)'(popcnt);
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state     <= SEARCH;
         hist      <= '0;
         clean_cnt <= '0;
         bad_cnt   <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         errcnt    <= '0;
         errsat    <= 1'b0;
      end else begin
         err <= 1'b0;
         if (en && valid_in) begin
            hist <= seq[N +: K];
            case (state)
               SEARCH: begin
                  if (any_mis) begin
                     clean_cnt <= '0;
                  end else if (clean_cnt == CW'(LOCK_WORDS - 1)) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     clean_cnt <= '0;
                     bad_cnt   <= '0;
                  end else begin
                     clean_cnt <= clean_cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  err <= any_mis;
                  if (sum[ERRW]) begin
                     errcnt <= CNT_MAX;
                     errsat <= 1'b1;
                  end else begin
                     errcnt <= sum[ERRW-1:0];
                     if (sum[ERRW-1:0] == CNT_MAX) begin
                        errsat <= 1'b1;
                     end
                  end
                  if (!any_mis) begin
                     bad_cnt <= '0;
                  end else if (bad_cnt == BW'(UNLOCK_WORDS - 1)) begin
                     state     <= SEARCH;
                     locked    <= 1'b0;
                     clean_cnt <= '0;
                     bad_cnt   <= '0;
                  end else begin
                     bad_cnt <= bad_cnt + 1'b1;
                  end
               end
               default: begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
         // Placed last so a same-cycle clear discards that word's count.
         if (clear) begin
            errcnt <= '0;
            errsat <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_la_prbs_checker.sv
`default_nettype none
// tb_la_prbs_checker -- directed bench with a bit-stream reference model.
module tb_la_prbs_checker;

   localparam int N = 8;
   localparam int K = 7;
   localparam int LOCKW = 4;
   localparam int UNLOCKW = 4;
   localparam int ERRW = 4;
   localparam int CMAX = 15;

   logic       clk = 1'b0;
   logic       nreset, en, clear, valid_in;
   logic [7:0] din;
   logic       locked, err, errsat;
   logic [3:0] errcnt;

   la_prbs_checker #(
      .N(N), .TYPE("PRBS7"), .LOCK_WORDS(LOCKW),
      .UNLOCK_WORDS(UNLOCKW), .ERRW(ERRW)
   ) dut (
      .clk(clk), .nreset(nreset), .en(en), .clear(clear),
      .valid_in(valid_in), .din(din), .locked(locked), .err(err),
      .errcnt(errcnt), .errsat(errsat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic cmp(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Reference model: a running bit stream, one bit at a time.
   bit mq[$];
   bit mlocked = 0, merr = 0, msat = 0;
   int mclean = 0, mbad = 0, mcnt = 0;

   task automatic model_step(input logic e, input logic v, input logic [7:0] d,
                             input logic c, input logic r);
      int nmis;
      bit p, m;
      if (!r) begin
         mq.delete();
         for (int i = 0; i < K; i++) mq.push_back(1'b0);
         mlocked = 0; merr = 0; msat = 0; mclean = 0; mbad = 0; mcnt = 0;
         return;
      end
      merr = 0;
      if (e && v) begin
         nmis = 0;
         for (int i = 0; i < N; i++) begin
            p = mq[mq.size()-7] ^ mq[mq.size()-6];
            m = d[i] ^ p;
            nmis += int'(m);
            mq.push_back(mlocked ? p : d[i]);
            mq.pop_front();
         end
         if (!mlocked) begin
            if (nmis > 0) mclean = 0;
            else begin
               mclean++;
               if (mclean == LOCKW) begin mlocked = 1; mclean = 0; mbad = 0; end
            end
         end else begin
            merr = (nmis > 0);
            if (!c) begin
               mcnt = (mcnt + nmis > CMAX) ? CMAX : mcnt + nmis;
               if (mcnt == CMAX) msat = 1;
            end
            if (nmis > 0) begin
               mbad++;
               if (mbad == UNLOCKW) begin mlocked = 0; mclean = 0; mbad = 0; end
            end else mbad = 0;
         end
      end
      if (c) begin mcnt = 0; msat = 0; end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("locked", locked, mlocked);
         cmp("err", err, merr);
         cmp("errcnt", errcnt, mcnt);
         cmp("errsat", errsat, msat);
      end
   end

   // PRBS7 source: seven seed ones, then s[n] = s[n-7] ^ s[n-6].
   bit gq[$];

   function automatic logic [7:0] gen_peek();
      bit t[$];
      bit b;
      logic [7:0] w;
      t = gq;
      for (int i = 0; i < 8; i++) begin
         if (t.size() < 7) b = 1'b1;
         else b = t[t.size()-7] ^ t[t.size()-6];
         w[i] = b;
         t.push_back(b);
      end
      return w;
   endfunction

   task automatic gen_commit(input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         gq.push_back(w[i]);
         if (gq.size() > 7) gq.pop_front();
      end
   endtask

   task automatic step(input logic e, input logic v, input logic [7:0] d,
                       input logic c, input logic r);
      en = e; valid_in = v; din = d; clear = c; nreset = r;
      @(posedge clk);
      model_step(e, v, d, c, r);
      #2;
   endtask

   task automatic word(input logic [7:0] flip, input logic c);
      logic [7:0] w;
      w = gen_peek();
      step(1'b1, 1'b1, w ^ flip, c, 1'b1);
      gen_commit(w);
   endtask

   bit pat[7]  = '{1, 1, 1, 0, 1, 1, 1};
   int expc[7] = '{3, 6, 9, 9, 12, 15, 15};

   initial begin
      int processed;
      int guard;
      int sel;
      en = 0; valid_in = 0; din = '0; clear = 0; nreset = 0;
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      chk_on = 1'b1;
      cmp("rst_locked", locked, 0);
      cmp("rst_errcnt", errcnt, 0);
      cmp("rst_err", err, 0);

      // Lock: first word errors against zero history, so lock on word 5.
      for (int k = 0; k < 4; k++) begin
         word(8'h00, 0);
         cmp("lock_pre", locked, 0);
      end
      word(8'h00, 0);
      cmp("lock_at5", locked, 1);
      cmp("lock_cnt", errcnt, 0);
      repeat (3) word(8'h00, 0);

      // Single flipped bit.
      word(8'h08, 0);
      cmp("single_err", err, 1);
      cmp("single_cnt", errcnt, 1);
      word(8'h00, 0);
      cmp("single_err_off", err, 0);
      repeat (5) word(8'h00, 0);
      cmp("single_locked", locked, 1);
      cmp("single_cnt_hold", errcnt, 1);
      word(8'h00, 1);
      cmp("clear_cnt", errcnt, 0);

      // Multi-bit errors up to saturation.
      for (int i = 0; i < 7; i++) begin
         word(pat[i] ? 8'h25 : 8'h00, 0);
         cmp("sat_cnt", errcnt, expc[i]);
         cmp("sat_flag", errsat, (i >= 5) ? 1 : 0);
         cmp("sat_locked", locked, 1);
      end
      word(8'h00, 0);
      word(8'h00, 1);
      cmp("sat_clr_cnt", errcnt, 0);
      cmp("sat_clr_flag", errsat, 0);

      // Loss of lock on all-ones words, then relock.
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 8'hFF, 0, 1);
         cmp("unlock_pre", locked, 1);
      end
      step(1, 1, 8'hFF, 0, 1);
      cmp("unlock", locked, 0);
      repeat (6) word(8'h00, 0);
      cmp("relock", locked, 1);

      // Handshake gaps and enable-low periods after a fresh reset.
      step(0, 0, 8'h00, 0, 0);
      gq.delete();
      processed = 0;
      guard = 0;
      while (processed < 5 && guard < 200) begin
         guard++;
         sel = int'($urandom_range(0, 3));
         if (sel == 0) step(1, 0, 8'($urandom()), 0, 1);
         else if (sel == 1) step(0, 1, 8'($urandom()), 0, 1);
         else begin
            word(8'h00, 0);
            processed++;
            cmp("gap_lock", locked, (processed == 5) ? 1 : 0);
         end
      end
      cmp("gap_budget", processed, 5);

      // Reset while locked with a nonzero count.
      word(8'h07, 0);
      word(8'h81, 0);
      cmp("pre_rst_cnt", errcnt, 5);
      step(1, 1, 8'hFF, 1, 0);
      cmp("midrst_locked", locked, 0);
      cmp("midrst_cnt", errcnt, 0);
      cmp("midrst_err", err, 0);
      cmp("midrst_sat", errsat, 0);

      // Clear on the same cycle as an errored word.
      gq.delete();
      repeat (5) word(8'h00, 0);
      cmp("corner_lock", locked, 1);
      word(8'h10, 0);
      cmp("corner_cnt1", errcnt, 1);
      word(8'h10, 1);
      cmp("corner_err", err, 1);
      cmp("corner_cnt0", errcnt, 0);
      repeat (2) word(8'h00, 0);

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/la_prbs_checker.md
Name: la_prbs_checker

Overview:
- Receive-side PRBS checker; pairs with the team's XOR-based PRBS/scrambler generators on link bring-up and BIST paths.
- Self-seeds from the incoming parallel bit stream and locks to it.
- Once locked, compares each received bit against the XOR-predicted bit and counts mismatches in a saturating counter.

Parameters:
- N, 8: bits per word on din; legal range 1..64.
- TYPE, "PRBS7": polynomial; one of "PRBS7" (x^7+x^6+1), "PRBS15" (x^15+x^14+1), "PRBS23" (x^23+x^18+1), "PRBS31" (x^31+x^28+1). K = degree (7/15/23/31).
- LOCK_WORDS, 4: consecutive clean valid words required to declare lock; must be ≥ ceil(K/N)+1.
- UNLOCK_WORDS, 4: consecutive errored valid words that drop lock.
- ERRW, 16: error counter width.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- nreset, input, 1: synchronous active-low reset.
- en, input, 1: checker enable; when low, state frozen and valid_in ignored.
- clear, input, 1: synchronous clear of errcnt and errsat.
- valid_in, input, 1: din carries a word this cycle.
- din, input, N: received bits; din[0] is the earliest bit in time.
- locked, output, 1: checker is in LOCKED.
- err, output, 1: one-cycle pulse; LOCKED word had ≥1 mismatch.
- errcnt, output, ERRW: saturating count of mismatched bits while LOCKED.
- errsat, output, 1: errcnt has reached all-ones.

Behaviour:
- Reset (nreset=0 at clk edge): state=SEARCH, history=0, clean/bad counters=0, locked=0, err=0, errcnt=0, errsat=0. Applies mid-operation, including from LOCKED; it overrides en and clear.
- A word is processed only when en=1 and valid_in=1. Otherwise all state holds and err=0 the next cycle.
- Prediction:
  - Form the bit sequence {history (K bits, oldest first), din[0..N-1]}.
  - For each din[i], predicted bit p[i] = s[i−tapA] XOR s[i−tapB], where tapA=K and tapB is the second tap (PRBS7:6, PRBS15:14, PRBS23:18, PRBS31:28), counted back in that sequence.
  - Mismatch m[i] = din[i] XOR p[i].
  - Chained prediction within a word is combinational; no extra pipeline stage.
- SEARCH state:
  - History source = received bits: new history = last K bits of the sequence.
  - Word with zero mismatches: clean counter +1. Any mismatch: clean counter resets to 0.
  - Mismatches in SEARCH never touch err or errcnt.
  - When the clean counter reaches LOCK_WORDS: state becomes LOCKED and locked=1 on the edge that processes that word; bad counter=0.
  - Startup words with zero history produce transient mismatches. These only reset the clean counter.
- LOCKED state:
  - History source = predicted bits p[], not din. The reference free-runs, so a single flipped bit counts as exactly one error.
  - err registered = OR(m[]); latency 1 cycle after the word is presented.
  - errcnt += popcount(m), saturating at 2^ERRW−1. errsat=1 when the saturated value is reached; it stays until clear or reset.
  - Bad-word counter: +1 on a word with any mismatch, reset to 0 on a clean word.
  - When the bad counter reaches UNLOCK_WORDS: go to SEARCH, locked=0, clean counter=0, history reloads from received bits starting with the next word. errcnt keeps its value.
- clear=1: errcnt=0 and errsat=0 at that edge. If the same cycle also has errors, clear wins and that word's errors are discarded. err still pulses, and the lock FSM is unaffected.
- Simultaneous lock and error: the word that completes LOCK_WORDS is by definition clean; counting starts with the following word.
- N<K and N≥K are both legal. Width of popcount = clog2(N+1); the add is done at ERRW+1 bits, then saturated.

Test Plan:
- Lock: PRBS7, N=8, seed 7'h7F, continuous clean stream, valid every cycle -> locked=1 after the edge of valid word 4 (transients may delay it by ≤1 word after reset, since history starts at 0); errcnt=0, err never high.
- Single error: while locked, flip din[3] of one word -> err=1 for exactly one cycle, errcnt=1; with history from prediction, following words are clean and locked stays 1.
- Multi-bit and saturation: ERRW=4; inject 3 flipped bits per word for 6 words (UNLOCK_WORDS=8) -> errcnt 3,6,9,12,15,15; errsat=1 from the 5th word on; clear -> errcnt=0, errsat=0.
- Loss of lock: locked, then all-ones words -> after 4 errored words locked=0. Resume a valid PRBS7 stream -> re-locks after LOCK_WORDS clean words; errcnt is held during SEARCH.
- Handshake gaps and enable: insert random valid_in=0 cycles and en=0 periods in a clean stream -> lock timing counts only processed words; no err pulses.
- Reset and clear corner: assert nreset=0 for one cycle while locked with errcnt=5 -> all outputs 0 next cycle. Separately, clear asserted together with an errored word -> errcnt=0 and err=1.
